// File: rtl/proc_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | proc_ctrl_pkg                                                              |
// | Opcode constants, ALU select codes and FSM state encodings for the lab     |
// | processor control unit.                                                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package proc_ctrl_pkg;

  localparam logic [3:0] c_op_noop  = 4'd0;
  localparam logic [3:0] c_op_store = 4'd1;
  localparam logic [3:0] c_op_load  = 4'd2;
  localparam logic [3:0] c_op_add   = 4'd3;
  localparam logic [3:0] c_op_sub   = 4'd4;
  localparam logic [3:0] c_op_halt  = 4'd5;
  localparam logic [3:0] c_op_jmpz  = 4'd6;

  localparam logic [2:0] c_alu_pass = 3'd0;
  localparam logic [2:0] c_alu_add  = 3'd1;
  localparam logic [2:0] c_alu_sub  = 3'd2;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JMPZ   = 4'd10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/proc_controller_param.sv
// +----------------------------------------------------------------------------+
// | proc_controller_param                                                      |
// | Parametrised control FSM: fetch handshake, decode, multi-cycle load,       |
// | illegal-opcode trap. Optional conditional jump under PROC_CTRL_JMPZ_EN.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module proc_controller_param
  import proc_ctrl_pkg::*;
#(
  parameter int RF_ADDR_W   = 4,
  parameter int MEM_LATENCY = 1,
  localparam int ADDR_W     = 2 * RF_ADDR_W,
  localparam int INSTR_W    = 4 + 3 * RF_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [INSTR_W-1:0]   instruction,
  input  logic                 i_ready,
  output logic                 ld,
  output logic                 pc_clr,
  output logic                 pc_up,
  output logic [ADDR_W-1:0]    d_addr,
  output logic                 d_wr,
  output logic                 rf_s,
  output logic [RF_ADDR_W-1:0] rf_w_addr,
  output logic                 rf_w_wr,
  output logic [RF_ADDR_W-1:0] rf_ra_addr,
  output logic                 rf_ra_rd,
  output logic [RF_ADDR_W-1:0] rf_rb_addr,
  output logic                 rf_rb_rd,
  output logic [2:0]           alu_s0,
  output logic [3:0]           state_o,
  output logic                 halted,
`ifdef PROC_CTRL_JMPZ_EN
  input  logic                 ra_zero,
  output logic                 pc_ld,
  output logic [ADDR_W-1:0]    pc_target,
`endif
  output logic                 illegal_op
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] c_lat_last = CNT_W'(MEM_LATENCY - 1);

  state_t             r_state;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_lat_cnt;

  logic [3:0]           w_opcode;
  logic [RF_ADDR_W-1:0] w_fa;
  logic [RF_ADDR_W-1:0] w_fb;
  logic [RF_ADDR_W-1:0] w_fw;
  logic [ADDR_W-1:0]    w_ld_addr;
  logic [ADDR_W-1:0]    w_st_addr;

  assign w_opcode  = instruction[INSTR_W-1 -: 4];
  assign w_fa      = instruction[INSTR_W-5 -: RF_ADDR_W];
  assign w_fb      = instruction[2*RF_ADDR_W-1 -: RF_ADDR_W];
  assign w_fw      = instruction[RF_ADDR_W-1:0];
  assign w_ld_addr = instruction[3*RF_ADDR_W-1:RF_ADDR_W];
  assign w_st_addr = instruction[2*RF_ADDR_W-1:0];

  assign state_o    = r_state;
  assign illegal_op = r_illegal;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_INIT;
      r_illegal <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT:   r_state <= S_FETCH;
        S_FETCH:  if (i_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_opcode)
            c_op_noop:  r_state <= S_NOOP;
            c_op_store: r_state <= S_STORE;
            c_op_load:  r_state <= S_LOAD_A;
            c_op_add:   r_state <= S_ADD;
            c_op_sub:   r_state <= S_SUB;
            c_op_halt:  r_state <= S_HALT;
`ifdef PROC_CTRL_JMPZ_EN
            c_op_jmpz:  r_state <= S_JMPZ;
`else
            c_op_jmpz: begin
              r_illegal <= 1'b1;
              r_state   <= S_HALT;
            end
`endif
            default: begin
              r_illegal <= 1'b1;
              r_state   <= S_HALT;
            end
          endcase
        end
        S_NOOP:   r_state <= S_FETCH;
        // Memory read data is valid once MEM_LATENCY cycles have elapsed in LOAD_A
        S_LOAD_A: begin
          if (r_lat_cnt == c_lat_last) begin
            r_lat_cnt <= '0;
            r_state   <= S_LOAD_B;
          end else begin
            r_lat_cnt <= r_lat_cnt + CNT_W'(1);
          end
        end
        S_LOAD_B: r_state <= S_FETCH;
        S_STORE:  r_state <= S_FETCH;
        S_ADD:    r_state <= S_FETCH;
        S_SUB:    r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
`ifdef PROC_CTRL_JMPZ_EN
        S_JMPZ:   r_state <= S_FETCH;
`endif
        default:  r_state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    ld         = 1'b0;
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_ra_addr = '0;
    rf_ra_rd   = 1'b0;
    rf_rb_addr = '0;
    rf_rb_rd   = 1'b0;
    alu_s0     = c_alu_pass;
    halted     = 1'b0;
`ifdef PROC_CTRL_JMPZ_EN
    pc_ld      = 1'b0;
    pc_target  = '0;
`endif
    case (r_state)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: begin
        ld    = i_ready;
        pc_up = i_ready;
      end
      S_LOAD_A, S_LOAD_B: begin
        d_addr    = w_ld_addr;
        rf_s      = 1'b1;
        rf_w_addr = w_fw;
        rf_w_wr   = (r_state == S_LOAD_B);
      end
      S_STORE: begin
        d_addr     = w_st_addr;
        d_wr       = 1'b1;
        rf_ra_addr = w_fa;
        rf_ra_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = w_fa;
        rf_ra_rd   = 1'b1;
        rf_rb_addr = w_fb;
        rf_rb_rd   = 1'b1;
        rf_w_addr  = w_fw;
        rf_w_wr    = 1'b1;
        alu_s0     = (r_state == S_ADD) ? c_alu_add : c_alu_sub;
      end
      S_HALT:  halted = 1'b1;
`ifdef PROC_CTRL_JMPZ_EN
      S_JMPZ: begin
        rf_ra_addr = w_fa;
        rf_ra_rd   = 1'b1;
        if (ra_zero) begin
          pc_ld     = 1'b1;
          pc_target = w_st_addr;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire
